timebase_tick_gen: RTL
======================

Name: timebase_tick_gen

Overview:
- Synthesisable, parametrised successor to the behavioural frequency-select clock source.
- Runs on the single system clock and turns a mode select into a programmable-period tick enable (one-cycle pulse) and the decoded frequency code.
- Mode changes are applied only at tick boundaries, giving glitch-free period switching for the controller's phase timers; the tick is also counted.

Parameters:
SEL_W, 2, mode-select width; 2**SEL_W modes
BASE_FREQ, 1, frequency code of mode 0; mode k code = BASE_FREQ << k
FREQ_W, 4, width of freq_code
TICK_SCALE, 1000, clock cycles per tick per frequency unit; period P(k) = (BASE_FREQ << k) * TICK_SCALE
CNT_W, 14, period counter width; must satisfy max P <= 2**CNT_W
TCNT_W, 8, tick_count width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  count enable
clr  input  1  synchronous clear of period counter and tick_count
sel_req  input  SEL_W  requested frequency mode
freq_code  output  FREQ_W  decoded frequency of active mode (BASE_FREQ << cur_sel)
tick  output  1  registered one-cycle pulse, once per period
tick_count  output  TCNT_W  number of ticks issued, wraps
mode_pending  output  1  high while sel_req != active mode
minute_tick  output  1  see Optional Feature

Behaviour:
- Reset (async, any time including mid-period): cur_sel=0, cnt=0, tick=0, tick_count=0, minute_tick=0, sec_cnt=0; freq_code=BASE_FREQ.
- All state is registered; freq_code and mode_pending are combinational from cur_sel/sel_req.
- Priority per edge: rst > clr > en.
- clr=1: cnt<=0, tick<=0, tick_count<=0, sec_cnt<=0; cur_sel<=sel_req.
- en=0 (clr=0): cnt holds its value, tick<=0, cur_sel unchanged (pause, not restart).
- en=1, cnt != P(cur_sel)-1: cnt<=cnt+1, tick<=0.
- en=1, cnt == P(cur_sel)-1 (terminal): cnt<=0, tick<=1, tick_count<=tick_count+1 (wraps to 0 at all-ones), cur_sel<=sel_req.
- Tick latency: starting from cnt=0, tick goes high on the P-th enabled edge. Consecutive ticks are exactly P enabled cycles apart. tick never stays high more than one cycle.
- Mode switch: a sel_req change mid-period does not affect the current period. The new P takes effect in the period following the next tick. mode_pending is high until that edge.
- sel_req changed back before the boundary: no switch occurs and mode_pending drops immediately.
- Arithmetic: P computed at CNT_W+1 bits. Parameter combinations where max P > 2**CNT_W are illegal; the implementation flags them with an elaboration-time $error. P=1 is legal: tick is high every enabled cycle.
- freq_code is truncated to FREQ_W; parameters must keep it in range.

Optional Feature:
- Macro: TIMEBASE_MINUTE_TICK_EN.
- Defined: internal 6-bit sec_cnt advances on each tick, wrapping 59->0. minute_tick is a one-cycle pulse coincident with the tick on which sec_cnt wraps, i.e. every 60th tick. sec_cnt is cleared by rst and clr.
- Undefined: sec_cnt is not built and minute_tick is tied to 0.

Test Plan:
- Params BASE_FREQ=1, TICK_SCALE=10, CNT_W=8; rst pulse, then en=1, sel_req=0 -> tick on edges 10, 20, 30; tick_count=3; freq_code=1.
- sel_req=3 at edge 15 -> mode_pending=1 from 15; tick at 20 (old P); mode_pending=0 after 20; next ticks at 100, 180 (P=80); freq_code=8 after edge 20.
- en=0 for 7 cycles starting at cnt=4 -> cnt holds 4, no tick; on resume, tick after 6 further enabled edges.
- clr at cnt=5 with tick_count=2 -> cnt=0, tick_count=0; next tick 10 enabled edges later.
- rst asserted asynchronously mid-period in mode 2 -> all outputs at reset values immediately; freq_code=1.
- With TIMEBASE_MINUTE_TICK_EN, mode 0 -> minute_tick only on edge 600, coincident with tick; without the macro -> minute_tick stays 0 throughout.

Source files
------------

// File: rtl/timebase_tick_gen_if.sv
// Control/status bundle for timebase_tick_gen: the controller drives the mode and
// enables, and the tick generator returns its tick, count and decoded frequency.
interface timebase_tick_gen_if #(
  parameter int SEL_W  = 2,
  parameter int FREQ_W = 4,
  parameter int TCNT_W = 8
);
  logic              en;
  logic              clr;
  logic [SEL_W-1:0]  sel_req;
  logic [FREQ_W-1:0] freq_code;
  logic              tick;
  logic [TCNT_W-1:0] tick_count;
  logic              mode_pending;
  logic              minute_tick;

  modport master (
    output en, clr, sel_req,
    input  freq_code, tick, tick_count, mode_pending, minute_tick
  );

  modport slave (
    input  en, clr, sel_req,
    output freq_code, tick, tick_count, mode_pending, minute_tick
  );
endinterface

// File: rtl/timebase_tick_gen.sv
// Programmable-period tick enable with mode changes taken only at tick boundaries.
// Optional macro TIMEBASE_MINUTE_TICK_EN adds a 60-tick sec_cnt and minute_tick pulse.
module timebase_tick_gen #(
  parameter int SEL_W      = 2,
  parameter int BASE_FREQ  = 1,
  parameter int FREQ_W     = 4,
  parameter int TICK_SCALE = 1000,
  parameter int CNT_W      = 14,
  parameter int TCNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  timebase_tick_gen_if.slave bus
);

  localparam longint MAX_CODE = longint'(BASE_FREQ) << ((1 << SEL_W) - 1);
  localparam longint MAX_P    = MAX_CODE * longint'(TICK_SCALE);

  if (MAX_P > (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("timebase_tick_gen: longest period %0d does not fit CNT_W=%0d", MAX_P, CNT_W);
  end
  if (MAX_CODE >= (longint'(1) << FREQ_W)) begin : g_bad_freq_w
    $error("timebase_tick_gen: frequency code %0d does not fit FREQ_W=%0d", MAX_CODE, FREQ_W);
  end

  // Terminal count P(k)-1; P is formed wider than the counter so P = 2**CNT_W is legal.
  function automatic logic [CNT_W-1:0] term_of(input logic [SEL_W-1:0] k);
    longint p;
    p = (longint'(BASE_FREQ) << k) * longint'(TICK_SCALE) - longint'(1);
    return p[CNT_W-1:0];
  endfunction

  function automatic logic [FREQ_W-1:0] freq_of(input logic [SEL_W-1:0] k);
    longint f;
    f = longint'(BASE_FREQ) << k;
    return f[FREQ_W-1:0];
  endfunction

  logic [SEL_W-1:0]  sel_req;
  logic              en;
  logic              clr;
  logic [SEL_W-1:0]  cur_sel;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic [TCNT_W-1:0] tick_count;
  logic              terminal;

  assign sel_req  = bus.sel_req;
  assign en       = bus.en;
  assign clr      = bus.clr;
  assign terminal = (cnt == term_of(cur_sel));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      tick       <= 1'b0;
      tick_count <= '0;
      cur_sel    <= '0;
    end else if (clr) begin
      cnt        <= '0;
      tick       <= 1'b0;
      tick_count <= '0;
      cur_sel    <= sel_req;
    end else if (!en) begin
      tick       <= 1'b0;
    end else if (terminal) begin
      cnt        <= '0;
      tick       <= 1'b1;
      tick_count <= tick_count + TCNT_W'(1);
      cur_sel    <= sel_req;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      tick       <= 1'b0;
    end
  end

  assign bus.tick         = tick;
  assign bus.tick_count   = tick_count;
  assign bus.freq_code    = freq_of(cur_sel);
  assign bus.mode_pending = (sel_req != cur_sel);

`ifdef TIMEBASE_MINUTE_TICK_EN
  logic [5:0] sec_cnt;
  logic       minute_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt     <= '0;
      minute_tick <= 1'b0;
    end else if (clr) begin
      sec_cnt     <= '0;
      minute_tick <= 1'b0;
    end else if (en && terminal) begin
      if (sec_cnt == 6'd59) begin
        sec_cnt     <= '0;
        minute_tick <= 1'b1;
      end else begin
        sec_cnt     <= sec_cnt + 6'd1;
        minute_tick <= 1'b0;
      end
    end else begin
      minute_tick <= 1'b0;
    end
  end

  assign bus.minute_tick = minute_tick;
`else
  assign bus.minute_tick = 1'b0;
`endif

endmodule
